// File: rtl/alu_exec_stage.sv
// 64-bit integer ALU execute stage: one elastic stage with an output register and a skid register, 1-cycle latency.
// in_ready is a flop and drops only when the skid entry is occupied; flush empties the stage and refuses that cycle's input.
module alu_exec_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [63:0] in_a,
   input  logic [63:0] in_b,
   input  logic [4:0]  in_tag,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_result,
   output logic [4:0]  out_tag,
   output logic [3:0]  out_flags
);

   typedef struct packed {
      logic [63:0] result;
      logic [4:0]  tag;
      logic [3:0]  flags;   // {ZF, SF, OF, CF}
   } res_t;

   typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_SRA = 3'b111;

   state_t state, state_nxt;
   logic   ready_q;
   res_t   out_q, skid_q, new_res;
   logic   accept, drain;
   logic   load_out_new, load_out_skid, load_skid;

   // ---------------- datapath ----------------
   logic [64:0] sum65, lsh, rsh;
   logic [63:0] diff, res;
   logic        of, cf;

   always_comb begin
      sum65 = {1'b0, in_a} + {1'b0, in_b};
      diff  = in_a - in_b;
      // Shifters carry one guard bit so the last bit shifted out falls into it.
      lsh   = {1'b0, in_a};
      rsh   = {in_a, 1'b0};
      for (int i = 0; i < 6; i++) begin
         if (in_b[i]) begin
            lsh = lsh << (1 << i);
            if (in_op == OP_SRA) rsh = $signed(rsh) >>> (1 << i);
            else                 rsh = rsh >> (1 << i);
         end
      end

      res = '0;
      of  = 1'b0;
      cf  = 1'b0;
      case (in_op)
         OP_ADD: begin
            res = sum65[63:0];
            cf  = sum65[64];
            of  = (in_a[63] == in_b[63]) && (sum65[63] != in_a[63]);
         end
         OP_SUB: begin
            res = diff;
            cf  = in_a < in_b;
            of  = (in_a[63] != in_b[63]) && (diff[63] != in_a[63]);
         end
         OP_AND: res = in_a & in_b;
         OP_OR:  res = in_a | in_b;
         OP_XOR: res = in_a ^ in_b;
         OP_SLL: begin
            res = lsh[63:0];
            cf  = lsh[64];
         end
         default: begin
            res = rsh[64:1];
            cf  = rsh[0];
         end
      endcase

      new_res.result = res;
      new_res.tag    = in_tag;
      new_res.flags  = {(res == 64'd0), res[63], of, cf};
   end

   // ---------------- control ----------------
   always_comb begin
      accept        = in_valid && ready_q && !flush;
      drain         = (state != EMPTY) && out_ready;
      state_nxt     = state;
      load_out_new  = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state_nxt    = FULL;
                  load_out_new = 1'b1;
               end
            end
            FULL: begin
               if (accept && drain) begin
                  load_out_new = 1'b1;
               end else if (accept) begin
                  state_nxt = SKID;
                  load_skid = 1'b1;
               end else if (drain) begin
                  state_nxt = EMPTY;
               end
            end
            SKID: begin
               if (drain) begin
                  state_nxt     = FULL;
                  load_out_skid = 1'b1;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= EMPTY;
         ready_q <= 1'b1;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt != SKID);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out_new)       out_q <= new_res;
         else if (load_out_skid) out_q <= skid_q;
         if (flush)              skid_q <= '0;
         else if (load_skid)     skid_q <= new_res;
      end
   end

   assign in_ready   = ready_q;
   assign out_valid  = (state != EMPTY);
   assign out_result = out_q.result;
   assign out_tag    = out_q.tag;
   assign out_flags  = out_q.flags;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed and randomized bench for alu_exec_stage; expected values are hand-computed or come from a behavioural model.
module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_op = '0;
   logic [63:0] in_a = '0;
   logic [63:0] in_b = '0;
   logic [4:0]  in_tag = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_result;
   logic [4:0]  out_tag;
   logic [3:0]  out_flags;

   int checks = 0;
   int failures = 0;

   alu_exec_stage dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .out_flags(out_flags)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag);
      in_valid = v;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_tag   = tag;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
      checks++; if (out_result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", out_result); end
      checks++; if (out_tag !== 5'd0) begin failures++; $display("FAIL reset_tag got=%0d exp=0", out_tag); end
      checks++; if (out_flags !== 4'd0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", out_flags); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_alu_vectors();
      localparam int N = 19;
      logic [2:0]  op_t [N];
      logic [63:0] a_t [N];
      logic [63:0] b_t [N];
      logic [63:0] r_t [N];
      logic [3:0]  f_t [N];
      op_t[0]  = 3'd0; a_t[0]  = 64'h7FFF_FFFF_FFFF_FFFF; b_t[0]  = 64'd1;  r_t[0]  = 64'h8000_0000_0000_0000; f_t[0]  = 4'b0110;
      op_t[1]  = 3'd0; a_t[1]  = 64'hFFFF_FFFF_FFFF_FFFF; b_t[1]  = 64'd1;  r_t[1]  = 64'd0;                  f_t[1]  = 4'b1001;
      op_t[2]  = 3'd0; a_t[2]  = 64'h8000_0000_0000_0000; b_t[2]  = 64'h8000_0000_0000_0000; r_t[2] = 64'd0;   f_t[2]  = 4'b1011;
      op_t[3]  = 3'd1; a_t[3]  = 64'd5;  b_t[3]  = 64'd5;  r_t[3]  = 64'd0;                  f_t[3]  = 4'b1000;
      op_t[4]  = 3'd1; a_t[4]  = 64'd0;  b_t[4]  = 64'd1;  r_t[4]  = 64'hFFFF_FFFF_FFFF_FFFF; f_t[4]  = 4'b0101;
      op_t[5]  = 3'd1; a_t[5]  = 64'h8000_0000_0000_0000; b_t[5]  = 64'd1;  r_t[5]  = 64'h7FFF_FFFF_FFFF_FFFF; f_t[5]  = 4'b0010;
      op_t[6]  = 3'd2; a_t[6]  = 64'hF0F0; b_t[6]  = 64'hFF00; r_t[6]  = 64'hF000;           f_t[6]  = 4'b0000;
      op_t[7]  = 3'd3; a_t[7]  = 64'h8000_0000_0000_0000; b_t[7]  = 64'd1;  r_t[7]  = 64'h8000_0000_0000_0001; f_t[7]  = 4'b0100;
      op_t[8]  = 3'd4; a_t[8]  = 64'h8000_0000_0000_0001; b_t[8]  = 64'd1;  r_t[8]  = 64'h8000_0000_0000_0000; f_t[8]  = 4'b0100;
      op_t[9]  = 3'd4; a_t[9]  = 64'h1234; b_t[9]  = 64'h1234; r_t[9]  = 64'd0;              f_t[9]  = 4'b1000;
      op_t[10] = 3'd5; a_t[10] = 64'd1;  b_t[10] = 64'hFFFF_FFFF_FFFF_FF03; r_t[10] = 64'd8; f_t[10] = 4'b0000;
      op_t[11] = 3'd5; a_t[11] = 64'hC000_0000_0000_0000; b_t[11] = 64'd1;  r_t[11] = 64'h8000_0000_0000_0000; f_t[11] = 4'b0101;
      op_t[12] = 3'd6; a_t[12] = 64'd3;  b_t[12] = 64'd1;  r_t[12] = 64'd1;                  f_t[12] = 4'b0001;
      op_t[13] = 3'd6; a_t[13] = 64'h8000_0000_0000_0000; b_t[13] = 64'd63; r_t[13] = 64'd1; f_t[13] = 4'b0000;
      op_t[14] = 3'd7; a_t[14] = 64'h8000_0000_0000_0000; b_t[14] = 64'd1;  r_t[14] = 64'hC000_0000_0000_0000; f_t[14] = 4'b0100;
      op_t[15] = 3'd7; a_t[15] = 64'hFFFF_FFFF_FFFF_FF9C; b_t[15] = 64'd2;  r_t[15] = 64'hFFFF_FFFF_FFFF_FFE7; f_t[15] = 4'b0100;
      op_t[16] = 3'd7; a_t[16] = 64'd5;  b_t[16] = 64'h40; r_t[16] = 64'd5;                  f_t[16] = 4'b0000;
      op_t[17] = 3'd7; a_t[17] = 64'h8000_0000_0000_0000; b_t[17] = 64'd63; r_t[17] = 64'hFFFF_FFFF_FFFF_FFFF; f_t[17] = 4'b0100;
      op_t[18] = 3'd5; a_t[18] = 64'd3;  b_t[18] = 64'd63; r_t[18] = 64'h8000_0000_0000_0000; f_t[18] = 4'b0101;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         drive(1'b1, op_t[i], a_t[i], b_t[i], 5'(i));
         step();
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL vec%0d_valid got=%0b exp=1", i, out_valid); end
         checks++; if (out_result !== r_t[i]) begin failures++; $display("FAIL vec%0d_result got=%h exp=%h", i, out_result, r_t[i]); end
         checks++; if (out_flags !== f_t[i]) begin failures++; $display("FAIL vec%0d_flags got=%b exp=%b", i, out_flags, f_t[i]); end
         checks++; if (out_tag !== 5'(i)) begin failures++; $display("FAIL vec%0d_tag got=%0d exp=%0d", i, out_tag, i); end
      end
      drive(1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL vec_drain_valid got=%0b exp=0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 64'd1, 64'd2, 5'd1);
      step();
      checks++; if (out_valid !== 1'b1 || out_result !== 64'd3) begin failures++; $display("FAIL bp_first got valid=%0b res=%0d exp valid=1 res=3", out_valid, out_result); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_full got=%0b exp=1", in_ready); end
      drive(1'b1, 3'd0, 64'd10, 64'd20, 5'd2);
      step();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_skid got=%0b exp=0", in_ready); end
      checks++; if (out_result !== 64'd3 || out_tag !== 5'd1) begin failures++; $display("FAIL bp_hold1 got res=%0d tag=%0d exp res=3 tag=1", out_result, out_tag); end
      drive(1'b1, 3'd1, 64'd9, 64'd4, 5'd3);
      step();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_third got=%0b exp=0", in_ready); end
      checks++; if (out_result !== 64'd3 || out_tag !== 5'd1 || out_flags !== 4'b0000) begin failures++; $display("FAIL bp_hold2 got res=%0d tag=%0d flags=%b exp res=3 tag=1 flags=0000", out_result, out_tag, out_flags); end
      drive(1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1 || out_result !== 64'd30 || out_tag !== 5'd2) begin failures++; $display("FAIL bp_second got valid=%0b res=%0d tag=%0d exp valid=1 res=30 tag=2", out_valid, out_result, out_tag); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%0b exp=1", in_ready); end
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_third got=%0b exp=0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 64'd7, 64'd0, 5'd4);
      step();
      flush = 1'b1;
      drive(1'b1, 3'd0, 64'd8, 64'd0, 5'd5);
      step();
      flush = 1'b0;
      drive(1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_full_valid got=%0b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_full_ready got=%0b exp=1", in_ready); end
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_offered_taken got=%0b exp=0", out_valid); end
      drive(1'b1, 3'd0, 64'd1, 64'd0, 5'd6);
      step();
      drive(1'b1, 3'd0, 64'd2, 64'd0, 5'd7);
      step();
      flush = 1'b1;
      drive(1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
      step();
      flush = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_skid got valid=%0b ready=%0b exp valid=0 ready=1", out_valid, in_ready); end
      out_ready = 1'b1;
      drive(1'b1, 3'd0, 64'd1, 64'd1, 5'd8);
      step();
      drive(1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
      checks++; if (out_result !== 64'd2 || out_tag !== 5'd8) begin failures++; $display("FAIL flush_resume got res=%0d tag=%0d exp res=2 tag=8", out_result, out_tag); end
      step();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 64'd5, 64'd5, 5'd9);
      step();
      drive(1'b1, 3'd0, 64'd6, 64'd6, 5'd10);
      step();
      drive(1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ctrl got valid=%0b ready=%0b exp valid=0 ready=1", out_valid, in_ready); end
      checks++; if (out_result !== 64'd0 || out_tag !== 5'd0 || out_flags !== 4'd0) begin failures++; $display("FAIL rstmid_data got res=%h tag=%0d flags=%b exp 0", out_result, out_tag, out_flags); end
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_skid_leak got=%0b exp=0", out_valid); end
   endtask

   function automatic void model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] r, output logic [3:0] f);
      logic o, c;
      int   n;
      n = int'(b[5:0]);
      o = 1'b0;
      c = 1'b0;
      case (op)
         3'd0: begin r = a + b; c = (r < a); o = (a[63] == b[63]) && (r[63] != a[63]); end
         3'd1: begin r = a - b; c = (a < b); o = (a[63] != b[63]) && (r[63] != a[63]); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: begin r = a << n; if (n != 0) c = a[64 - n]; end
         3'd6: begin r = a >> n; if (n != 0) c = a[n - 1]; end
         default: begin r = $signed(a) >>> n; if (n != 0) c = a[n - 1]; end
      endcase
      f = {(r == 64'd0), r[63], o, c};
   endfunction

   typedef struct {
      logic [63:0] r;
      logic [4:0]  t;
      logic [3:0]  f;
   } exp_t;

   task automatic test_random();
      exp_t q[$];
      exp_t e;
      int   xfers = 0;
      int   cyc = 0;
      while (xfers < 10000 && cyc < 60000) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(9) < 7);
         in_op     = 3'($urandom_range(7));
         in_a      = {$urandom, $urandom};
         in_b      = ($urandom_range(1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(70));
         in_tag    = 5'($urandom_range(31));
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               if (failures < 20) $display("FAIL rand_extra got tag=%0d exp=no output", out_tag);
            end else begin
               e = q.pop_front();
               if (out_result !== e.r || out_tag !== e.t || out_flags !== e.f) begin
                  failures++;
                  if (failures < 20) $display("FAIL rand_xfer%0d got res=%h tag=%0d flags=%b exp res=%h tag=%0d flags=%b", xfers, out_result, out_tag, out_flags, e.r, e.t, e.f);
               end
            end
            xfers++;
         end
         if (in_valid && in_ready) begin
            model(in_op, in_a, in_b, e.r, e.f);
            e.t = in_tag;
            q.push_back(e);
         end
         step();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (out_valid) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL rand_drain_extra got tag=%0d exp=no output", out_tag);
            end else begin
               e = q.pop_front();
               if (out_result !== e.r || out_tag !== e.t || out_flags !== e.f) begin
                  failures++;
                  $display("FAIL rand_drain got res=%h tag=%0d exp res=%h tag=%0d", out_result, out_tag, e.r, e.t);
               end
            end
            xfers++;
         end
         step();
      end
      checks++; if (q.size() != 0) begin failures++; $display("FAIL rand_lost got pending=%0d exp=0", q.size()); end
      checks++; if (xfers < 10000) begin failures++; $display("FAIL rand_count got=%0d exp>=10000", xfers); end
   endtask

   initial begin
      test_reset();
      test_alu_vectors();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 in_valid  input  1  upstream offers an operation this cycle.
REQ-005 in_ready  output  1  stage can accept an operation this cycle.
REQ-006 in_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA.
REQ-007 in_a  input  64  operand A; the value that is shifted for shift ops.
REQ-008 in_b  input  64  operand B; bits [5:0] are the shift amount for shift ops.
REQ-009 in_tag  input  5  destination-register tag, carried unmodified.
REQ-010 flush  input  1  discard any held result.
REQ-011 out_valid  output  1  registered result available.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 out_result  output  64  registered result.
REQ-014 out_tag  output  5  tag of the held result.
REQ-015 out_flags  output  4  {ZF, SF, OF, CF} of the held result.

Function
REQ-016 SHALL be a single elastic pipeline stage with a 1-entry output register and a 1-entry skid register (states EMPTY, FULL, SKID).
REQ-017 in_ready SHALL be 1 in EMPTY and FULL and 0 in SKID; it SHALL be driven only from registers.
REQ-018 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-019 Latency SHALL be exactly 1 cycle: an op accepted at edge N SHALL be presented on out_* after edge N when the output register is free.
REQ-020 Transitions: EMPTY+accept->FULL; FULL+accept+drain->FULL (new data); FULL+accept+no drain->SKID (new op parked in skid); FULL+drain only->EMPTY; SKID+drain->FULL (skid moves to output); otherwise hold.
REQ-021 out_result, out_tag and out_flags SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 ADD/SUB SHALL compute A+B and A-B modulo 2^64; CF SHALL be the carry-out for ADD and the borrow (A<B unsigned) for SUB; OF SHALL be signed overflow.
REQ-023 AND/OR/XOR SHALL be bitwise; OF=0 and CF=0.
REQ-024 SLL/SRL SHALL shift A by B[5:0] filling with zeros; SRA SHALL shift by B[5:0] filling with A[63]; B[63:6] SHALL be ignored.
REQ-025 For shifts, CF SHALL be the last bit shifted out (0 when the amount is 0); OF=0.
REQ-026 ZF SHALL be (result==0); SF SHALL be result[63], for all ops.
REQ-027 The result SHALL be computed combinationally from in_* and captured at acceptance; the shifter SHALL be a 6-level logarithmic (1/2/4/8/16/32) mux chain.
REQ-028 flush SHALL force EMPTY on the next edge, clear out_valid and drop skid contents; an input offered in the same cycle as flush SHALL NOT be accepted.
REQ-029 flush SHALL take priority over simultaneous accept and drain; rst_n SHALL take priority over flush.

Reset
REQ-030 With rst_n=0 at a rising edge: state EMPTY, out_valid=0, in_ready=1, out_result=0, out_tag=0, out_flags=0, skid cleared.
REQ-031 Reset asserted mid-transfer SHALL discard held and skid results with no output transfer.

Verification
REQ-032 ADD A=0x7FFFFFFFFFFFFFFF, B=1 -> next cycle out_result=0x8000000000000000, flags ZF=0 SF=1 OF=1 CF=0.
REQ-033 SRA A=0x8000000000000000, B=1 -> 0xC000000000000000, CF=0; SRA A=-100, B=2 -> -25 (0xFFFFFFFFFFFFFFE7), CF=0.
REQ-034 SUB A=5, B=5 -> result 0, ZF=1 CF=0; SUB A=0, B=1 -> 0xFFFFFFFFFFFFFFFF, CF=1, SF=1.
REQ-035 Backpressure: out_ready=0, issue three back-to-back ops -> first two accepted, in_ready=0 on third; raise out_ready -> results drained in order, no loss or duplication.
REQ-036 flush with FULL state and in_valid=1 -> next cycle out_valid=0, in_ready=1, offered op not accepted.
REQ-037 Random ops vs. reference model, random in_valid/out_ready, 10k transfers -> all results, tags and flags match, in order.
